mdr_sequencer: RTL and testbench

//  Control unit (initiator) for the shared MDR ALU. Accepts MULT/DIV/ROOT requests,

---
 rtl/pkg_system_mdr.sv | 45 ++++
 rtl/mdr_seq_counter.sv | 32 +++
 rtl/mdr_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_mdr_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_system_mdr.sv
// Shared types and constants for the MDR sequencer and its sibling ALU.
// Operand width, ALU selectors, sequencer states and per-operation iteration counts.
package pkg_system_mdr;

  localparam int unsigned DW    = 16;
  localparam int unsigned CNT_W = $clog2(DW) + 1;

  typedef logic [DW-1:0]    data_t;
  typedef logic [2*DW-1:0]  data_in_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    NULL = 2'd0,
    ADD  = 2'd1,
    SUBS = 2'd2
  } op_t;

  typedef enum logic [1:0] {
    MULT = 2'd0,
    DIV  = 2'd1,
    ROOT = 2'd2
  } op_select_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } seq_state_t;

  localparam cnt_t MULT_ITERS = cnt_t'(DW);
  localparam cnt_t DIV_ITERS  = cnt_t'(DW);
  localparam cnt_t ROOT_ITERS = cnt_t'(DW / 2);

  // Index of the final iteration; illegal ops never reach ITER.
  function automatic cnt_t last_iter(op_select_t op);
    case (op)
      MULT:    return MULT_ITERS - cnt_t'(1);
      DIV:     return DIV_ITERS - cnt_t'(1);
      ROOT:    return ROOT_ITERS - cnt_t'(1);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mdr_seq_counter.sv
// Loadable up/down iteration counter with a terminal-count flag.
// The flag is combinational on the current count against a supplied terminal value.
module mdr_seq_counter #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic         i_up,
  input  logic [W-1:0] i_load_val,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= i_load_val;
    end else if (i_en) begin
      cnt_q <= i_up ? cnt_q + W'(1) : cnt_q - W'(1);
    end
  end

  assign o_cnt = cnt_q;
  assign o_tc  = (cnt_q == i_term);

endmodule

// File: rtl/mdr_sequencer.sv
// Initiator for the shared MDR ALU: iterative shift-add multiply, restoring divide
// and restoring square root, one ALU operation per cycle.
module mdr_sequencer
  import pkg_system_mdr::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  op_select_t i_op,
  input  data_t      i_data_a,
  input  data_t      i_data_b,
  output op_t        o_sltr,
  output logic       o_enable,
  output op_select_t o_alu_op,
  output logic       o_flag,
  output data_in_t   o_val_a_M,
  output data_in_t   o_val_b_M,
  output data_t      o_val_a_DR,
  output data_t      o_val_b_DR,
  input  data_in_t   i_alu_val_M,
  input  data_t      i_alu_val_DR,
  input  logic       i_alu_flag,
  output data_in_t   o_result,
  output data_t      o_remainder,
  output logic       o_busy,
  output logic       o_ready,
  output logic       o_error
);

  seq_state_t state, state_nxt;

  op_select_t op_q;
  data_t      a_q, b_q;
  data_in_t   acc_q;
  data_t      rem_q, quo_q;
  data_in_t   result_q;
  data_t      remainder_q;
  logic       error_q;

  cnt_t       cnt;
  logic       cnt_tc;
  logic       load_err;

  data_t      a_shl, a_shl2, b_shr;
  logic       mul_bit;
  data_t      div_r_sh, root_r_sh, root_t;
  logic       div_ge, root_ge;
  data_in_t   acc_nxt;
  data_t      rem_nxt, quo_nxt;

  mdr_seq_counter #(
    .W (CNT_W)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (state != ITER),
    .i_en       (state == ITER),
    .i_up       (1'b1),
    .i_load_val ('0),
    .i_term     (last_iter(op_q)),
    .o_cnt      (cnt),
    .o_tc       (cnt_tc)
  );

  assign load_err = ((op_q == DIV) && (b_q == '0)) || !(op_q inside {MULT, DIV, ROOT});

  // Per-iteration operand selection and next accumulator values.
  always_comb begin
    a_shl     = a_q << cnt;
    a_shl2    = a_q << {cnt, 1'b0};
    b_shr     = b_q >> cnt;
    mul_bit   = b_shr[0];
    div_r_sh  = {rem_q[DW-2:0], a_shl[DW-1]};
    div_ge    = (div_r_sh >= b_q);
    root_r_sh = {rem_q[DW-3:0], a_shl2[DW-1 -: 2]};
    root_t    = {quo_q[DW-3:0], 2'b01};
    root_ge   = (root_r_sh >= root_t);
    acc_nxt   = acc_q;
    rem_nxt   = rem_q;
    quo_nxt   = quo_q;
    case (op_q)
      MULT: acc_nxt = i_alu_val_M;
      DIV: begin
        rem_nxt = i_alu_flag ? i_alu_val_DR : div_r_sh;
        quo_nxt = {quo_q[DW-2:0], i_alu_flag};
      end
      ROOT: begin
        rem_nxt = root_ge ? i_alu_val_DR : root_r_sh;
        quo_nxt = {quo_q[DW-2:0], root_ge};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_start) state_nxt = LOAD;
      LOAD: state_nxt = load_err ? DONE : ITER;
      ITER: if (cnt_tc) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_sltr     = NULL;
    o_enable   = 1'b0;
    o_alu_op   = MULT;
    o_flag     = 1'b0;
    o_val_a_M  = '0;
    o_val_b_M  = '0;
    o_val_a_DR = '0;
    o_val_b_DR = '0;
    if (state == ITER) begin
      o_enable = 1'b1;
      o_alu_op = op_q;
      case (op_q)
        MULT: begin
          o_sltr    = mul_bit ? ADD : NULL;
          o_val_a_M = acc_q;
          o_val_b_M = data_in_t'(a_q) << cnt;
        end
        DIV: begin
          o_sltr     = SUBS;
          o_flag     = div_ge;
          o_val_a_DR = div_r_sh;
          o_val_b_DR = b_q;
        end
        ROOT: begin
          o_sltr     = root_ge ? SUBS : NULL;
          o_val_a_DR = root_r_sh;
          o_val_b_DR = root_t;
        end
        default: ;
      endcase
    end
  end

  // Operands are captured on the accepting edge so the LOAD cycle can check them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= MULT;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      error_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            op_q        <= i_op;
            a_q         <= i_data_a;
            b_q         <= i_data_b;
            acc_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            error_q     <= 1'b0;
          end
        end
        LOAD: error_q <= load_err;
        ITER: begin
          acc_q <= acc_nxt;
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          if (cnt_tc) begin
            result_q    <= (op_q == MULT) ? acc_nxt : data_in_t'(quo_nxt);
            remainder_q <= (op_q == MULT) ? '0 : rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_result    = result_q;
  assign o_remainder = remainder_q;
  assign o_error     = error_q;
  assign o_busy      = (state != IDLE);
  assign o_ready     = (state == DONE);

endmodule

// File: tb/tb_mdr_sequencer.sv
// Randomised bench for mdr_sequencer with a behavioural ALU beside it and an
// arithmetic reference model (a*b, a/b, a%b, integer square root).
module tb_mdr_sequencer;
  import pkg_system_mdr::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  op_select_t i_op = MULT;
  data_t      i_data_a = '0;
  data_t      i_data_b = '0;
  op_t        o_sltr;
  logic       o_enable;
  op_select_t o_alu_op;
  logic       o_flag;
  data_in_t   o_val_a_M, o_val_b_M;
  data_t      o_val_a_DR, o_val_b_DR;
  data_in_t   alu_val_M;
  data_t      alu_val_DR;
  logic       alu_flag;
  data_in_t   o_result;
  data_t      o_remainder;
  logic       o_busy, o_ready, o_error;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mdr_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_op         (i_op),
    .i_data_a     (i_data_a),
    .i_data_b     (i_data_b),
    .o_sltr       (o_sltr),
    .o_enable     (o_enable),
    .o_alu_op     (o_alu_op),
    .o_flag       (o_flag),
    .o_val_a_M    (o_val_a_M),
    .o_val_b_M    (o_val_b_M),
    .o_val_a_DR   (o_val_a_DR),
    .o_val_b_DR   (o_val_b_DR),
    .i_alu_val_M  (alu_val_M),
    .i_alu_val_DR (alu_val_DR),
    .i_alu_flag   (alu_flag),
    .o_result     (o_result),
    .o_remainder  (o_remainder),
    .o_busy       (o_busy),
    .o_ready      (o_ready),
    .o_error      (o_error)
  );

  // Behavioural sibling ALU: NULL passes operand a, ADD adds, SUBS subtracts
  // (for DIV only when the sequencer permits it, reporting that it did).
  always_comb begin
    alu_val_M  = o_val_a_M;
    alu_val_DR = o_val_a_DR;
    alu_flag   = 1'b0;
    if (o_enable) begin
      case (o_sltr)
        ADD:  alu_val_M = o_val_a_M + o_val_b_M;
        SUBS: begin
          if (o_alu_op == DIV) begin
            if (o_flag) begin
              alu_val_DR = o_val_a_DR - o_val_b_DR;
              alu_flag   = 1'b1;
            end
          end else begin
            alu_val_DR = o_val_a_DR - o_val_b_DR;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ref_model(input logic [1:0] op, input data_t a, input data_t b,
                           output data_in_t res, output data_t rem, output logic err,
                           output int lat);
    int unsigned r;
    res = '0; rem = '0; err = 1'b0; lat = 2;
    case (op)
      2'd0: begin res = data_in_t'(a) * data_in_t'(b); lat = DW + 2; end
      2'd1: begin
        if (b == '0) err = 1'b1;
        else begin res = data_in_t'(a / b); rem = a % b; lat = DW + 2; end
      end
      2'd2: begin
        r = 0;
        while ((r + 1) * (r + 1) <= int'(a)) r++;
        res = data_in_t'(r);
        rem = data_t'(int'(a) - r * r);
        lat = DW / 2 + 2;
      end
      default: err = 1'b1;
    endcase
  endtask

  task automatic do_op(input logic [1:0] op, input data_t a, input data_t b, input string tag);
    data_in_t exp_res;
    data_t    exp_rem;
    logic     exp_err;
    int       exp_lat;
    int       cyc;
    bit       seen;
    bit       en_seen;
    ref_model(op, a, b, exp_res, exp_rem, exp_err, exp_lat);
    @(negedge clk);
    i_start = 1'b1; i_op = op_select_t'(op); i_data_a = a; i_data_b = b;
    @(posedge clk);
    #1 i_start = 1'b0;
    cyc = 1; seen = 1'b0; en_seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      if (o_enable) en_seen = 1'b1;
      if (o_ready) seen = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    check_val({tag, "_ready"}, seen, 1);
    check_val({tag, "_latency"}, cyc, exp_lat);
    check_val({tag, "_result"}, o_result, exp_res);
    check_val({tag, "_rem"}, o_remainder, exp_rem);
    check_val({tag, "_error"}, o_error, exp_err);
    if (exp_err) check_val({tag, "_enable_seen"}, en_seen, 0);
    @(negedge clk);
    check_val({tag, "_ready_pulse"}, o_ready, 0);
    check_val({tag, "_busy_after"}, o_busy, 0);
    check_val({tag, "_result_held"}, o_result, exp_res);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int     first;
    int     second;
    int     ready_cnt;
    data_in_t got_res;
    logic [1:0] op;
    data_t  a, b;
    int     sel;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_ready", o_ready, 0);
    check_val("rst_enable", o_enable, 0);
    check_val("rst_sltr", o_sltr, NULL);
    check_val("rst_result", o_result, 0);
    check_val("rst_rem", o_remainder, 0);
    check_val("rst_error", o_error, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    do_op(2'd0, 16'h00FF, 16'h0101, "mult_ff_101");
    do_op(2'd1, 16'd100, 16'd7, "div_100_7");
    do_op(2'd1, 16'hFFFF, 16'd1, "div_ffff_1");
    do_op(2'd2, 16'd144, 16'd0, "root_144");
    do_op(2'd2, 16'hFFFF, 16'd0, "root_ffff");
    do_op(2'd1, 16'd5, 16'd0, "div_by_zero");
    do_op(2'd3, 16'd9, 16'd3, "illegal_op");
    do_op(2'd0, 16'hFFFF, 16'hFFFF, "mult_max");

    // A start pulse during ITER must be ignored.
    @(negedge clk);
    i_start = 1'b1; i_op = MULT; i_data_a = 16'h00FF; i_data_b = 16'h0101;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    i_start = 1'b1; i_op = DIV; i_data_a = 16'd9; i_data_b = 16'd0;
    @(posedge clk);
    #1 i_start = 1'b0;
    ready_cnt = 0; got_res = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_ready) begin
        ready_cnt++;
        if (ready_cnt == 1) got_res = o_result;
      end
    end
    check_val("iter_start_ready_count", ready_cnt, 1);
    check_val("iter_start_result", got_res, 32'h0000FFFF);
    check_val("iter_start_error", o_error, 0);
    check_val("iter_start_busy", o_busy, 0);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    i_start = 1'b1; i_op = MULT; i_data_a = 16'h1234; i_data_b = 16'h5678;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_busy", o_busy, 0);
    check_val("midrst_enable", o_enable, 0);
    check_val("midrst_ready", o_ready, 0);
    check_val("midrst_result", o_result, 0);
    check_val("midrst_sltr", o_sltr, NULL);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'd0, 16'h1234, 16'h5678, "post_rst_mult");

    // Held start: a new op is accepted in the IDLE cycle after DONE.
    first = 0; second = 0;
    @(negedge clk);
    i_start = 1'b1; i_op = MULT; i_data_a = 16'd3; i_data_b = 16'd5;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_ready) begin
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
    end
    i_start = 1'b0;
    check_val("hold_start_first", first, DW + 2);
    check_val("hold_start_second", second, 2 * DW + 5);
    for (int k = 0; k < 40 && o_busy; k++) @(negedge clk);
    check_val("hold_start_idle", o_busy, 0);
    check_val("hold_start_result", o_result, 15);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      op = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      a = data_t'($urandom);
      b = data_t'($urandom);
      if (op == 2'd1 && $urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 3) == 0) b = data_t'($urandom_range(1, 15));
      do_op(op, a, b, $sformatf("rand%0d_op%0d", n, op));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
